mem_bus_arbiter: RTL

//  Shares the single 8-bit memory port between the three CPU requesters: instruction fetch,

---
 rtl/mem_bus_arbiter_pkg.sv | 32 +++
 rtl/mem_bus_arbiter_prio_pick.sv | 35 +++
 rtl/mem_bus_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared owner/state codes for the memory-port arbiter.
// No logic here; imported by mem_bus_arbiter and arb_prio_pick.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DT   = 2'd2,
        OWN_STK  = 2'd3
    } owner_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned STARVE_CNT_W = 8;

    // Request/exclude vectors are ordered {stk, dt, if}.
    function automatic logic [2:0] owner_mask(input owner_t owner);
        logic [2:0] mask;
        mask = 3'b000;
        case (owner)
            OWN_IF:  mask = 3'b001;
            OWN_DT:  mask = 3'b010;
            OWN_STK: mask = 3'b100;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_prio_pick.sv
// Purpose: combinational fixed-priority pick STK > DT > IF with exclude, stack lock and IF promotion.
// Latency: zero (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module arb_prio_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic       stk_req,
    input  logic       dt_req,
    input  logic       if_req,
    input  logic [2:0] excl,
    input  logic       lock,
    input  logic       promote,
    output owner_t     owner
);

    logic [2:0] cand;

    always_comb begin
        owner = OWN_NONE;
        cand  = {stk_req, dt_req, if_req} & ~excl;
        if (lock) begin
            // A locked stack burst admits nobody but the stack unit.
            owner = stk_req ? OWN_STK : OWN_NONE;
        end else if (cand[2]) begin
            owner = OWN_STK;
        end else if (promote && cand[0]) begin
            owner = OWN_IF;
        end else if (cand[1]) begin
            owner = OWN_DT;
        end else if (cand[0]) begin
            owner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one memory port between fetch, data and stack units; optional IF starvation guard (ARB_STARVE_GUARD_EN).
// Latency: request to done 2 cycles minimum; back-to-back owners switch with no idle cycle.
// Backpressure: each requester holds req until its done; mem_en holds the command until mem_rdy.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned AW           = 8,
    parameter int unsigned DW           = 8,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          dt_req,
    input  logic          dt_we,
    input  logic [AW-1:0] dt_addr,
    input  logic [DW-1:0] dt_wdata,
    input  logic          stk_req,
    input  logic          stk_we,
    input  logic [AW-1:0] stk_addr,
    input  logic [DW-1:0] stk_wdata,
    input  logic          stk_lock,
    output logic          if_gnt,
    output logic          dt_gnt,
    output logic          stk_gnt,
    output logic          if_done,
    output logic          dt_done,
    output logic          stk_done,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy
);

    arb_state_t    state_q, state_d;
    owner_t        owner_q, owner_d, pick;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q;
    logic          lock_q, lock_d;
    logic          busy, done_any, owner_req, promote;
    logic [2:0]    excl;

    assign busy     = (state_q == ARB_BUSY);
    assign done_any = busy && mem_rdy;
    assign excl     = done_any ? owner_mask(owner_q) : 3'b000;

    always_comb begin
        owner_req = 1'b0;
        case (owner_q)
            OWN_IF:  owner_req = if_req;
            OWN_DT:  owner_req = dt_req;
            OWN_STK: owner_req = stk_req;
            default: owner_req = 1'b0;
        endcase
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [STARVE_CNT_W-1:0] starve_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            starve_q <= '0;
        end else if (if_done) begin
            starve_q <= '0;
        end else if (if_req && !(busy && owner_q == OWN_IF) && starve_q != '1) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign promote = (32'(starve_q) >= STARVE_LIMIT);
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign promote = 1'b0;
`endif

    arb_prio_pick u_pick (
        .stk_req (stk_req),
        .dt_req  (dt_req),
        .if_req  (if_req),
        .excl    (excl),
        .lock    (lock_q),
        .promote (promote),
        .owner   (pick)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lock_q  <= lock_d;
            if (done_any && !we_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ARB_IDLE: begin
                lock_d  = 1'b0;
                owner_d = pick;
                if (pick != OWN_NONE) begin
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (mem_rdy) begin
                    // A locked stack access waits one cycle to see whether the burst continues.
                    if (owner_q == OWN_STK && stk_lock) begin
                        state_d = ARB_IDLE;
                        owner_d = OWN_NONE;
                        lock_d  = 1'b1;
                    end else if (pick != OWN_NONE) begin
                        owner_d = pick;
                    end else begin
                        state_d = ARB_IDLE;
                        owner_d = OWN_NONE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        if (state_d == ARB_BUSY && (state_q == ARB_IDLE || mem_rdy)) begin
            case (owner_d)
                OWN_IF: begin
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                end
                OWN_DT: begin
                    we_d    = dt_we;
                    addr_d  = dt_addr;
                    wdata_d = dt_wdata;
                end
                OWN_STK: begin
                    we_d    = stk_we;
                    addr_d  = stk_addr;
                    wdata_d = stk_wdata;
                end
                default: ;
            endcase
        end
    end

    assign if_gnt    = busy && (owner_q == OWN_IF);
    assign dt_gnt    = busy && (owner_q == OWN_DT);
    assign stk_gnt   = busy && (owner_q == OWN_STK);
    assign if_done   = if_gnt && mem_rdy;
    assign dt_done   = dt_gnt && mem_rdy;
    assign stk_done  = stk_gnt && mem_rdy;
    assign mem_en    = busy;
    assign mem_we    = busy && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    // Read data is forwarded in the done cycle and held afterwards.
    assign rdata     = (done_any && !we_q) ? mem_rdata : rdata_q;

    req_held_while_granted: assert property (
        @(posedge clk) disable iff (!reset_) busy |-> owner_req
    );

endmodule
